fwrisc_trace_driver: RTL and testbench
======================================

Name: fwrisc_trace_driver

Overview:
- Transmit end of the fwrisc execution-trace interface. Replays queued trace records onto the same pc/instr/ivalid, ra/rb, rd and memory-write signal bundle that trace monitors sample.
- Lets trace consumers be exercised without a core, and allows trace playback from a stimulus source.
- Records enter through a valid/ready push port into an internal FIFO. A small FSM pops each record, inserts a per-record idle gap, and emits one single-cycle strobe.

Parameters:
- FIFO_DEPTH, 8, record FIFO depth; must be a power of 2, minimum 2.
- GAP_W, 4, width of the per-record idle-gap field.

Ports:
- clock  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rec_valid  in  1  record push request.
- rec_ready  out  1  FIFO not full; push is accepted when rec_valid && rec_ready.
- rec_kind  in  2  record kind: 0 INSTR, 1 REG, 2 MEM, 3 NOP.
- rec_addr  in  32  INSTR: pc; REG: bits [5:0] give rd address; MEM: maddr.
- rec_data  in  32  INSTR: instr; REG: wdata; MEM: mdata.
- rec_strb  in  4  MEM byte strobes; ignored for other kinds.
- rec_gap  in  GAP_W  idle cycles to insert before this record is driven.
- pc, instr  out  32 each  instruction trace.
- ivalid  out  1  instruction strobe.
- ra_raddr, rb_raddr  out  6 each  source register addresses.
- ra_rdata, rb_rdata  out  32 each  source register values.
- rd_waddr  out  6  register-write address.
- rd_wdata  out  32  register-write data.
- rd_write  out  1  register-write strobe.
- maddr, mdata  out  32 each  memory-write address and data.
- mstrb  out  4  memory-write byte strobes.
- mwrite, mvalid  out  1 each  memory-write strobes; always asserted together.
- idle  out  1  FIFO empty and FSM in IDLE.
- instr_count  out  32  number of ivalid pulses emitted; wraps at 2^32.

Behaviour:
- Reset: all outputs 0 except rec_ready=1 and idle=1. FIFO is flushed, shadow register file cleared, instr_count=0, FSM to IDLE.
- Reset asserted mid-gap or mid-drive aborts the pending record. No strobe is emitted on the cycle following reset.
- Every output is registered. Strobes (ivalid, rd_write, mwrite/mvalid) are high for exactly one cycle per record. Data buses hold their last driven value between strobes.
- rec_ready = !full. It is not relieved by a pop in the same cycle. A push while full is not accepted and must be held by the source.
- FIFO order is strict; each record is popped exactly once.
- FSM IDLE:
  - If the FIFO is non-empty, pop.
  - gap==0: load the outputs on this edge, so the strobe is visible the next cycle. Stay in IDLE so the next record can pop the following edge; back-to-back gap-0 records give consecutive-cycle strobes.
  - gap>0: latch the record, set cnt=gap, go to GAP.
- FSM GAP:
  - cnt decrements each cycle. When cnt==1, load the outputs on that edge and return to IDLE.
  - Net effect: exactly rec_gap dead cycles between the pop-edge strobe slot and the strobe.
- Latency: push at edge N into an empty, idle driver with gap g → strobe high in the cycle after edge N+1+g.
- INSTR record:
  - pc=rec_addr, instr=rec_data, ivalid=1.
  - ra_raddr={1'b0,instr[19:15]}, rb_raddr={1'b0,instr[24:20]}.
  - ra_rdata/rb_rdata are the shadow values as they stood before this edge.
  - instr_count increments.
- REG record:
  - rd_waddr=rec_addr[5:0], rd_wdata=rec_data, rd_write=1.
  - Shadow entry is updated on the same edge, except address 0, whose shadow stays 0; the strobe is still emitted for address 0.
  - Shadow file has 64 entries, 32 bits each.
- MEM record: maddr=rec_addr, mdata=rec_data, mstrb=rec_strb, mwrite=mvalid=1.
- NOP record: consumes its gap, emits no strobe and changes no output. Use for timing padding.
- Only one strobe class is ever asserted in any cycle.
- idle is registered: high when the FIFO is empty and FSM==IDLE with no load on the current edge.

Test Plan:
- Reset then idle: after reset, all strobes 0, rec_ready=1, idle=1, instr_count=0 over 10 cycles.
- Single INSTR: push pc=0x80000000, instr=0x00310133 (add x2,x2,x3), gap 0 → exactly one ivalid cycle with pc/instr matching, ra_raddr=2, rb_raddr=3, ra_rdata=rb_rdata=0; instr_count=1.
- Shadow forwarding:
  - Push REG rd=3, wdata=0xDEADBEEF (gap 0), then the same INSTR (gap 0).
  - Required: rd_write pulse, then ivalid on the next cycle with rb_rdata=0xDEADBEEF.
  - Then a REG write to rd=0 with 0x55 followed by the INSTR leaves ra/rb for x0 reading 0.
- Gap timing: push MEM maddr=0x1000, mdata=0x12345678, strb=4'b0011, gap=5 → mwrite/mvalid pulse exactly 5 cycles later than the gap-0 case; NOP gap=3 between two INSTRs adds 3 dead cycles and no strobes.
- Full/back-pressure:
  - Hold rec_valid with FIFO_DEPTH+4 gap-0 INSTRs.
  - Required: rec_ready drops after 8 records are buffered, and all 12 emerge in order on 12 consecutive ivalid cycles.
  - instr_count=12.
- Reset mid-operation: push 4 records with gap 7, assert reset during the first gap → no strobe afterwards, idle=1, FIFO empty, shadow cleared (a subsequent INSTR reads ra_rdata=0).

Source files
------------

// File: rtl/fwrisc_trace_driver.sv
// Replays queued trace records onto the fwrisc execution-trace bundle.
// Records are buffered in a FIFO, held back by their per-record gap, then strobed for one cycle.
module fwrisc_trace_driver #(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_W      = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [1:0]       rec_kind,
    input  logic [31:0]      rec_addr,
    input  logic [31:0]      rec_data,
    input  logic [3:0]       rec_strb,
    input  logic [GAP_W-1:0] rec_gap,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             ivalid,
    output logic [5:0]       ra_raddr,
    output logic [5:0]       rb_raddr,
    output logic [31:0]      ra_rdata,
    output logic [31:0]      rb_rdata,
    output logic [5:0]       rd_waddr,
    output logic [31:0]      rd_wdata,
    output logic             rd_write,
    output logic [31:0]      maddr,
    output logic [31:0]      mdata,
    output logic [3:0]       mstrb,
    output logic             mwrite,
    output logic             mvalid,
    output logic             idle,
    output logic [31:0]      instr_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      DEPTH   = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]      ONE     = 1;
    localparam logic [GAP_W-1:0] GAP_ONE = 1;

    localparam logic [1:0] K_INSTR = 2'd0;
    localparam logic [1:0] K_REG   = 2'd1;
    localparam logic [1:0] K_MEM   = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [3:0]       strb;
        logic [GAP_W-1:0] gap;
    } rec_t;

    typedef enum logic {S_IDLE, S_GAP} state_t;

    rec_t             r_fifo [FIFO_DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    state_t           r_state;
    rec_t             r_rec;
    logic [GAP_W-1:0] r_cnt;
    logic [31:0]      r_shadow [64];

    rec_t        w_in;
    rec_t        w_head;
    rec_t        w_drv;
    logic [AW:0] w_count;
    logic [AW:0] w_countNext;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_gapDone;
    logic        w_load;
    logic        w_toGap;
    logic        w_idleNext;

    assign w_in        = {rec_kind, rec_addr, rec_data, rec_strb, rec_gap};
    assign w_count     = r_wrPtr - r_rdPtr;
    assign w_full      = (w_count == DEPTH);
    assign w_push      = rec_valid && !w_full;
    assign w_pop       = (r_state == S_IDLE) && (w_count != '0);
    assign w_head      = r_fifo[r_rdPtr[AW-1:0]];
    assign w_countNext = w_count + (w_push ? ONE : '0) - (w_pop ? ONE : '0);
    assign w_gapDone   = (r_state == S_GAP) && (r_cnt == GAP_ONE);
    assign w_toGap     = w_pop && (w_head.gap != '0);
    assign w_load      = (w_pop && (w_head.gap == '0)) || w_gapDone;
    assign w_drv       = (r_state == S_GAP) ? r_rec : w_head;
    assign w_idleNext  = (w_countNext == '0) && !w_load &&
                         ((r_state == S_IDLE && !w_toGap) || w_gapDone);

    // Ready reflects occupancy after this edge, so a same-edge pop never frees a slot early.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            rec_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_fifo[r_wrPtr[AW-1:0]] <= w_in;
                r_wrPtr                 <= r_wrPtr + ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ONE;
            end
            rec_ready <= (w_countNext != DEPTH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rec       <= '0;
            r_cnt       <= '0;
            pc          <= '0;
            instr       <= '0;
            ivalid      <= 1'b0;
            ra_raddr    <= '0;
            rb_raddr    <= '0;
            ra_rdata    <= '0;
            rb_rdata    <= '0;
            rd_waddr    <= '0;
            rd_wdata    <= '0;
            rd_write    <= 1'b0;
            maddr       <= '0;
            mdata       <= '0;
            mstrb       <= '0;
            mwrite      <= 1'b0;
            mvalid      <= 1'b0;
            idle        <= 1'b1;
            instr_count <= '0;
            for (int i = 0; i < 64; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            ivalid   <= 1'b0;
            rd_write <= 1'b0;
            mwrite   <= 1'b0;
            mvalid   <= 1'b0;
            idle     <= w_idleNext;

            case (r_state)
                S_IDLE: begin
                    if (w_toGap) begin
                        r_rec   <= w_head;
                        r_cnt   <= w_head.gap;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_gapDone) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - GAP_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // NOP records fall through the kind decode and leave every output untouched.
            if (w_load) begin
                case (w_drv.kind)
                    K_INSTR: begin
                        pc          <= w_drv.addr;
                        instr       <= w_drv.data;
                        ivalid      <= 1'b1;
                        ra_raddr    <= {1'b0, w_drv.data[19:15]};
                        rb_raddr    <= {1'b0, w_drv.data[24:20]};
                        ra_rdata    <= r_shadow[{1'b0, w_drv.data[19:15]}];
                        rb_rdata    <= r_shadow[{1'b0, w_drv.data[24:20]}];
                        instr_count <= instr_count + 32'd1;
                    end
                    K_REG: begin
                        rd_waddr <= w_drv.addr[5:0];
                        rd_wdata <= w_drv.data;
                        rd_write <= 1'b1;
                        if (w_drv.addr[5:0] != 6'd0) begin
                            r_shadow[w_drv.addr[5:0]] <= w_drv.data;
                        end
                    end
                    K_MEM: begin
                        maddr  <= w_drv.addr;
                        mdata  <= w_drv.data;
                        mstrb  <= w_drv.strb;
                        mwrite <= 1'b1;
                        mvalid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fwrisc_trace_driver.sv
// Bench for fwrisc_trace_driver: directed timing scenarios plus random records,
// checked against an in-order scoreboard and a 64-entry shadow register model.
module tb_fwrisc_trace_driver;
    localparam int FIFO_DEPTH = 8;
    localparam int GAP_W      = 4;
    localparam logic [1:0] K_INSTR = 2'd0;
    localparam logic [1:0] K_REG   = 2'd1;
    localparam logic [1:0] K_MEM   = 2'd2;
    localparam logic [1:0] K_NOP   = 2'd3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             rec_valid = 1'b0;
    logic             rec_ready;
    logic [1:0]       rec_kind = '0;
    logic [31:0]      rec_addr = '0;
    logic [31:0]      rec_data = '0;
    logic [3:0]       rec_strb = '0;
    logic [GAP_W-1:0] rec_gap = '0;
    logic [31:0]      pc, instr, ra_rdata, rb_rdata, rd_wdata, maddr, mdata, instr_count;
    logic [5:0]       ra_raddr, rb_raddr, rd_waddr;
    logic [3:0]       mstrb;
    logic             ivalid, rd_write, mwrite, mvalid, idle;

    fwrisc_trace_driver #(.FIFO_DEPTH(FIFO_DEPTH), .GAP_W(GAP_W)) dut (
        .clock(clock), .reset(reset),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_addr(rec_addr), .rec_data(rec_data), .rec_strb(rec_strb), .rec_gap(rec_gap),
        .pc(pc), .instr(instr), .ivalid(ivalid),
        .ra_raddr(ra_raddr), .rb_raddr(rb_raddr), .ra_rdata(ra_rdata), .rb_rdata(rb_rdata),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_write(rd_write),
        .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite), .mvalid(mvalid),
        .idle(idle), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  gap;
    } rec_t;

    rec_t        expQ[$];
    logic [31:0] shadowM [64];
    int          modelCount  = 0;
    int          checkCount  = 0;
    int          errorCount  = 0;
    int          strobeCount = 0;
    int          cycle       = 0;
    int          strobeCyc[$];

    always @(posedge clock) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clearModel();
        expQ.delete();
        foreach (shadowM[i]) shadowM[i] = '0;
        modelCount = 0;
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        rec_valid = 1'b0;
        clearModel();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard: every strobe must match the oldest queued non-NOP record, in push order.
    always @(negedge clock) begin
        int        nStrb;
        rec_t      e;
        logic [5:0] rs1, rs2;
        if (reset === 1'b0) begin
            nStrb = 32'(ivalid) + 32'(rd_write) + 32'(mwrite);
            if (nStrb != 0 || mvalid) begin
                strobeCount++;
                strobeCyc.push_back(cycle);
                checkOutput("one_strobe_class", 32'(nStrb), 32'd1);
                checkOutput("mvalid_eq_mwrite", 32'(mvalid), 32'(mwrite));
                while (expQ.size() > 0 && expQ[0].kind == K_NOP) void'(expQ.pop_front());
                checkOutput("strobe_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    case (e.kind)
                        K_INSTR: begin
                            rs1 = {1'b0, e.data[19:15]};
                            rs2 = {1'b0, e.data[24:20]};
                            modelCount++;
                            checkOutput("ivalid", 32'(ivalid), 32'd1);
                            checkOutput("pc", pc, e.addr);
                            checkOutput("instr", instr, e.data);
                            checkOutput("ra_raddr", 32'(ra_raddr), 32'(rs1));
                            checkOutput("rb_raddr", 32'(rb_raddr), 32'(rs2));
                            checkOutput("ra_rdata", ra_rdata, shadowM[rs1]);
                            checkOutput("rb_rdata", rb_rdata, shadowM[rs2]);
                            checkOutput("instr_count", instr_count, 32'(modelCount));
                        end
                        K_REG: begin
                            checkOutput("rd_write", 32'(rd_write), 32'd1);
                            checkOutput("rd_waddr", 32'(rd_waddr), 32'(e.addr[5:0]));
                            checkOutput("rd_wdata", rd_wdata, e.data);
                            if (e.addr[5:0] != 6'd0) shadowM[e.addr[5:0]] = e.data;
                        end
                        default: begin
                            checkOutput("mwrite", 32'(mwrite), 32'd1);
                            checkOutput("maddr", maddr, e.addr);
                            checkOutput("mdata", mdata, e.data);
                            checkOutput("mstrb", 32'(mstrb), 32'(e.strb));
                        end
                    endcase
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input logic [3:0] g, output int acc);
        bit ok = 0;
        rec_t r;
        rec_valid = 1'b1;
        rec_kind  = k;
        rec_addr  = a;
        rec_data  = d;
        rec_strb  = s;
        rec_gap   = g;
        acc       = -1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clock);
            if (rec_ready === 1'b1) begin
                @(posedge clock);
                #1;
                ok  = 1;
                acc = cycle;
            end
        end
        rec_valid = 1'b0;
        if (ok) begin
            r = '{kind: k, addr: a, data: d, strb: s, gap: g};
            expQ.push_back(r);
        end else begin
            checkOutput("push_accepted", 32'd0, 32'd1);
        end
    endtask

    task automatic waitStrobes(input int target, input int bound);
        for (int i = 0; i < bound && strobeCount < target; i++) @(negedge clock);
        checkOutput("strobe_arrived", 32'(strobeCount >= target), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic waitIdle(input int bound);
        for (int i = 0; i < bound && idle !== 1'b1; i++) @(negedge clock);
        checkOutput("idle_reached", 32'(idle), 32'd1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int acc, acc2, base, sc, s0, s3, d0, d5, left;
        logic [31:0] rd, ra;
        logic [1:0]  rk;

        resetDut();
        for (int i = 0; i < 10; i++) begin
            checkOutput("rst_strobes", 32'({ivalid, rd_write, mwrite, mvalid}), 32'd0);
            checkOutput("rst_ready", 32'(rec_ready), 32'd1);
            checkOutput("rst_idle", 32'(idle), 32'd1);
            checkOutput("rst_count", instr_count, 32'd0);
            @(posedge clock);
            #1;
        end
        checkOutput("rst_pc", pc, 32'd0);
        checkOutput("rst_maddr", maddr, 32'd0);

        // Single INSTR with gap 0: strobe one cycle after the accepting edge's pop.
        strobeCyc.delete();
        base = strobeCount;
        applyStimulus(K_INSTR, 32'h8000_0000, 32'h0031_0133, 4'h0, 4'd0, acc);
        waitStrobes(base + 1, 20);
        checkOutput("instr_latency", 32'(strobeCyc[0] - acc), 32'd1);
        checkOutput("instr_ra_raddr", 32'(ra_raddr), 32'd2);
        checkOutput("instr_rb_raddr", 32'(rb_raddr), 32'd3);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("instr_single_pulse", 32'(strobeCount - base), 32'd1);
        checkOutput("instr_count_one", instr_count, 32'd1);

        // Shadow forwarding, including the hardwired-zero x0.
        strobeCyc.delete();
        base = strobeCount;
        applyStimulus(K_REG, 32'd3, 32'hDEAD_BEEF, 4'h0, 4'd0, acc);
        applyStimulus(K_INSTR, 32'h8000_0004, 32'h0031_0133, 4'h0, 4'd0, acc);
        waitStrobes(base + 2, 20);
        checkOutput("fwd_consecutive", 32'(strobeCyc[1] - strobeCyc[0]), 32'd1);
        checkOutput("fwd_rb_rdata", rb_rdata, 32'hDEAD_BEEF);
        base = strobeCount;
        applyStimulus(K_REG, 32'd0, 32'h0000_0055, 4'h0, 4'd0, acc);
        applyStimulus(K_INSTR, 32'h8000_0008, 32'h0000_0033, 4'h0, 4'd0, acc);
        waitStrobes(base + 2, 20);
        checkOutput("x0_ra_rdata", ra_rdata, 32'd0);
        checkOutput("x0_rb_rdata", rb_rdata, 32'd0);
        checkOutput("x0_rd_wdata", rd_wdata, 32'h55);
        waitIdle(50);

        // Gap timing: gap 5 lands exactly 5 cycles later than gap 0.
        strobeCyc.delete();
        base = strobeCount;
        applyStimulus(K_MEM, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1111, 4'd0, acc);
        waitStrobes(base + 1, 20);
        d0 = strobeCyc[0] - acc;
        waitIdle(20);
        applyStimulus(K_MEM, 32'h0000_1000, 32'h1234_5678, 4'b0011, 4'd5, acc);
        waitStrobes(base + 2, 30);
        d5 = strobeCyc[1] - acc;
        checkOutput("gap0_latency", 32'(d0), 32'd1);
        checkOutput("gap5_extra", 32'(d5 - d0), 32'd5);
        checkOutput("gap5_mstrb", 32'(mstrb), 32'b0011);
        waitIdle(20);

        // A NOP occupies one slot plus its gap; gap 3 adds 3 dead cycles over gap 0.
        strobeCyc.delete();
        base = strobeCount;
        applyStimulus(K_INSTR, 32'h100, 32'h0000_0013, 4'h0, 4'd0, acc);
        applyStimulus(K_NOP, 32'h0, 32'h0, 4'h0, 4'd0, acc);
        applyStimulus(K_INSTR, 32'h104, 32'h0000_0013, 4'h0, 4'd0, acc);
        waitStrobes(base + 2, 20);
        waitIdle(20);
        applyStimulus(K_INSTR, 32'h108, 32'h0000_0013, 4'h0, 4'd0, acc);
        applyStimulus(K_NOP, 32'h0, 32'h0, 4'h0, 4'd3, acc);
        applyStimulus(K_INSTR, 32'h10C, 32'h0000_0013, 4'h0, 4'd0, acc);
        waitStrobes(base + 4, 30);
        s0 = strobeCyc[1] - strobeCyc[0];
        s3 = strobeCyc[3] - strobeCyc[2];
        checkOutput("nop0_spacing", 32'(s0), 32'd2);
        checkOutput("nop3_added_dead", 32'(s3 - s0), 32'd3);
        checkOutput("nop_no_strobe", 32'(strobeCount - base), 32'd4);
        waitIdle(20);

        // Back-pressure: a long NOP stalls the drain while FIFO_DEPTH+4 INSTRs queue up.
        resetDut();
        strobeCyc.delete();
        base = strobeCount;
        applyStimulus(K_NOP, 32'h0, 32'h0, 4'h0, 4'd15, acc);
        for (int i = 0; i < FIFO_DEPTH + 4; i++) begin
            applyStimulus(K_INSTR, 32'h400 + 32'(4 * i), 32'h0000_0013 | (32'(i) << 7), 4'h0, 4'd0, acc);
            if (i == FIFO_DEPTH - 2) checkOutput("ready_before_full", 32'(rec_ready), 32'd1);
            if (i == FIFO_DEPTH - 1) checkOutput("ready_when_full", 32'(rec_ready), 32'd0);
        end
        waitStrobes(base + FIFO_DEPTH + 4, 100);
        checkOutput("full_consecutive", 32'(strobeCyc[FIFO_DEPTH + 3] - strobeCyc[0]), 32'(FIFO_DEPTH + 3));
        checkOutput("full_instr_count", instr_count, 32'(FIFO_DEPTH + 4));
        waitIdle(20);

        // Reset during the first gap drops every pending record and clears the shadow file.
        applyStimulus(K_REG, 32'd2, 32'hCAFE_F00D, 4'h0, 4'd0, acc);
        waitIdle(20);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(K_INSTR, 32'h600 + 32'(4 * i), 32'h0031_0133, 4'h0, 4'd7, acc);
        end
        repeat (2) @(posedge clock);
        #1;
        sc = strobeCount;
        resetDut();
        repeat (30) @(posedge clock);
        #1;
        checkOutput("abort_no_strobe", 32'(strobeCount - sc), 32'd0);
        checkOutput("abort_idle", 32'(idle), 32'd1);
        checkOutput("abort_ready", 32'(rec_ready), 32'd1);
        checkOutput("abort_count", instr_count, 32'd0);
        applyStimulus(K_INSTR, 32'h700, 32'h0031_0133, 4'h0, 4'd0, acc2);
        waitStrobes(sc + 1, 20);
        checkOutput("abort_shadow_cleared", ra_rdata, 32'd0);
        waitIdle(20);

        // Random records with small gaps and a narrow register range to exercise forwarding.
        for (int i = 0; i < 40; i++) begin
            rk = 2'($urandom_range(0, 3));
            rd = $urandom;
            ra = $urandom;
            if (rk == K_REG) ra = 32'($urandom_range(0, 7));
            if (rk == K_INSTR) begin
                rd[19:15] = 5'($urandom_range(0, 7));
                rd[24:20] = 5'($urandom_range(0, 7));
            end
            applyStimulus(rk, ra, rd, 4'($urandom), 4'($urandom_range(0, 3)), acc);
        end
        waitIdle(600);
        left = 0;
        foreach (expQ[i]) if (expQ[i].kind != K_NOP) left++;
        checkOutput("random_all_emitted", 32'(left), 32'd0);
        checkOutput("random_instr_count", instr_count, 32'(modelCount));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
